gate_eval_arbiter: RTL and testbench

- Shares one multi-input gate evaluator (NAND-style, INPUT_COUNT inputs, 1-bit result) between REQ_COUNT requesting gate sites.
- Each requester pulses a trigger. The arbiter latches it as pending, grants the evaluator round-robin, and drives the winner's operands.
- It samples the evaluator result after a fixed latency and returns the result tagged with the requester id.
- Sits between the wiring-trigger logic and a single shared Gate_*-style evaluator instance.

---
 rtl/gate_eval_arbiter.sv | 155 +++++++++++++++
 tb/tb_gate_eval_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_eval_arbiter.sv
// gate_eval_arbiter: round-robin sharing of one multi-input gate evaluator between
// REQ_COUNT trigger sites; each result is returned tagged with its requester id.
module gate_eval_arbiter #(
  parameter int REQ_COUNT    = 4,
  parameter int INPUT_COUNT  = 2,
  parameter int EVAL_LATENCY = 1,
  parameter int ID_W         = 2
) (
  input  logic                             clk,
  input  logic                             logic_reset,
  input  logic [REQ_COUNT-1:0]             req,
  input  logic [REQ_COUNT*INPUT_COUNT-1:0] req_in,
  output logic [INPUT_COUNT-1:0]           eval_in,
  input  logic                             eval_result,
  output logic [REQ_COUNT-1:0]             grant,
  output logic                             resp_valid,
  output logic [ID_W-1:0]                  resp_id,
  output logic                             resp_value,
  output logic [REQ_COUNT-1:0]             pending,
  output logic                             coalesced,
  output logic                             busy
);

  localparam int CNT_W = (EVAL_LATENCY < 2) ? 1 : $clog2(EVAL_LATENCY + 1);
  localparam logic [REQ_COUNT-1:0] ONE_HOT0 = {{(REQ_COUNT-1){1'b0}}, 1'b1};
  localparam logic [ID_W-1:0]      LAST_ID  = ID_W'(REQ_COUNT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EVAL = 1'b1
  } state_t;

  state_t                 r_state;
  logic [REQ_COUNT-1:0]   r_pending;
  logic [REQ_COUNT-1:0]   r_grant;
  logic [INPUT_COUNT-1:0] r_eval_in;
  logic [ID_W-1:0]        r_win;
  logic [ID_W-1:0]        r_rr_ptr;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_resp_valid;
  logic [ID_W-1:0]        r_resp_id;
  logic                   r_resp_value;
  logic                   r_coalesced;

  logic                   w_found;
  logic [ID_W-1:0]        w_win;
  logic [INPUT_COUNT-1:0] w_operands;
  logic                   w_done;
  logic [REQ_COUNT-1:0]   w_clear;

  // Round-robin pick: first pending id at or above rr_ptr, otherwise wrap to the lowest.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (!w_found && r_pending[i] && (ID_W'(i) >= r_rr_ptr)) begin
        w_found = 1'b1;
        w_win   = ID_W'(i);
      end else begin
        w_found = w_found;
      end
    end
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (!w_found && r_pending[i]) begin
        w_found = 1'b1;
        w_win   = ID_W'(i);
      end else begin
        w_found = w_found;
      end
    end
  end

  // Operand mux selecting the winner's slice of req_in.
  always_comb begin
    w_operands = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (w_win == ID_W'(i)) begin
        w_operands = req_in[i*INPUT_COUNT +: INPUT_COUNT];
      end else begin
        w_operands = w_operands;
      end
    end
  end

  assign w_done  = (r_state == S_EVAL) && (r_cnt == CNT_W'(1));
  assign w_clear = w_done ? (ONE_HOT0 << r_win) : '0;

  // Pending latch: a new request wins over the completion clear on the same edge.
  always_ff @(posedge clk or posedge logic_reset) begin
    if (logic_reset) begin
      r_pending   <= '0;
      r_coalesced <= 1'b0;
    end else begin
      r_pending   <= (r_pending & ~w_clear) | req;
      r_coalesced <= |(req & r_pending & ~w_clear);
    end
  end

  // Grant / evaluate FSM with registered grant, operands and response.
  always_ff @(posedge clk or posedge logic_reset) begin
    if (logic_reset) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_eval_in    <= '0;
      r_win        <= '0;
      r_rr_ptr     <= '0;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_value <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant   <= ONE_HOT0 << w_win;
            r_eval_in <= w_operands;
            r_win     <= w_win;
            r_cnt     <= CNT_W'(EVAL_LATENCY);
            r_state   <= S_EVAL;
          end else begin
            r_grant <= '0;
          end
        end
        S_EVAL: begin
          if (r_cnt == CNT_W'(1)) begin
            r_resp_valid <= 1'b1;
            r_resp_id    <= r_win;
            r_resp_value <= eval_result;
            r_rr_ptr     <= (r_win == LAST_ID) ? '0 : r_win + ID_W'(1);
            r_grant      <= '0;
            r_cnt        <= '0;
            r_state      <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_grant <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign eval_in    = r_eval_in;
  assign grant      = r_grant;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_value = r_resp_value;
  assign pending    = r_pending;
  assign coalesced  = r_coalesced;
  assign busy       = (r_state == S_EVAL);

endmodule

// File: tb/tb_gate_eval_arbiter.sv
// Bench for gate_eval_arbiter: two instances (latency 1 and 3) driving a NAND evaluator,
// with a response scoreboard per instance plus table-driven and hand-written sequences.
module tb_gate_eval_arbiter;

  typedef struct packed {
    logic [1:0] id;
    logic       val;
  } exp_t;

  typedef struct {
    int         id;
    logic [1:0] op;
    logic       val;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_a, req_b;
  logic [7:0] req_in_a, req_in_b;
  logic [1:0] eval_in_a, eval_in_b;
  logic       eval_res_a, eval_res_b;
  logic [3:0] grant_a, grant_b;
  logic       resp_valid_a, resp_valid_b;
  logic [1:0] resp_id_a, resp_id_b;
  logic       resp_value_a, resp_value_b;
  logic [3:0] pending_a, pending_b;
  logic       coalesced_a, coalesced_b;
  logic       busy_a, busy_b;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_resp_a = 0;
  int   n_resp_b = 0;
  int   n_coal_b = 0;
  int   cyc = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  int   resp_cyc_a[$];
  exp_t e_a, e_b;
  vec_t vecs[6];
  int   base;
  int   c0;

  assign eval_res_a = ~&eval_in_a;
  assign eval_res_b = ~&eval_in_b;

  gate_eval_arbiter #(.REQ_COUNT(4), .INPUT_COUNT(2), .EVAL_LATENCY(1), .ID_W(2)) u_dut_a (
    .clk(clk), .logic_reset(rst), .req(req_a), .req_in(req_in_a), .eval_in(eval_in_a),
    .eval_result(eval_res_a), .grant(grant_a), .resp_valid(resp_valid_a), .resp_id(resp_id_a),
    .resp_value(resp_value_a), .pending(pending_a), .coalesced(coalesced_a), .busy(busy_a)
  );

  gate_eval_arbiter #(.REQ_COUNT(4), .INPUT_COUNT(2), .EVAL_LATENCY(3), .ID_W(2)) u_dut_b (
    .clk(clk), .logic_reset(rst), .req(req_b), .req_in(req_in_b), .eval_in(eval_in_b),
    .eval_result(eval_res_b), .grant(grant_b), .resp_valid(resp_valid_b), .resp_id(resp_id_b),
    .resp_value(resp_value_b), .pending(pending_b), .coalesced(coalesced_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [1:0] id, input logic val);
    exp_t e;
    e.id  = id;
    e.val = val;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(input string name, input bit on_b, input int target, input int budget);
    int n;
    for (int c = 0; c < budget; c++) begin
      n = on_b ? n_resp_b : n_resp_a;
      if (n >= target) break;
      tick();
    end
    n = on_b ? n_resp_b : n_resp_a;
    check(name, n, target);
  endtask

  // Scoreboard: every response must match the next expected {id, value}.
  always @(negedge clk) begin
    if (resp_valid_a) begin
      n_resp_a++;
      resp_cyc_a.push_back(cyc);
      check("resp_a_expected", (q_a.size() != 0), 1);
      if (q_a.size() != 0) begin
        e_a = q_a.pop_front();
        check("resp_a_id", resp_id_a, e_a.id);
        check("resp_a_value", resp_value_a, e_a.val);
      end
    end
    if (resp_valid_b) begin
      n_resp_b++;
      check("resp_b_expected", (q_b.size() != 0), 1);
      if (q_b.size() != 0) begin
        e_b = q_b.pop_front();
        check("resp_b_id", resp_id_b, e_b.id);
        check("resp_b_value", resp_value_b, e_b.val);
      end
    end
    if (coalesced_b) n_coal_b++;
  end

  initial begin
    rst = 1'b1; req_a = 4'b0000; req_b = 4'b0000; req_in_a = 8'h00; req_in_b = 8'h00;
    // Single-request vectors on the latency-1 instance; value is NAND of the operands.
    vecs[0] = '{id: 2, op: 2'b11, val: 1'b0};
    vecs[1] = '{id: 0, op: 2'b00, val: 1'b1};
    vecs[2] = '{id: 1, op: 2'b01, val: 1'b1};
    vecs[3] = '{id: 0, op: 2'b11, val: 1'b0};
    vecs[4] = '{id: 1, op: 2'b10, val: 1'b1};
    vecs[5] = '{id: 3, op: 2'b11, val: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_a_outputs", {grant_a, pending_a, eval_in_a, resp_valid_a, resp_id_a,
                            resp_value_a, coalesced_a, busy_a}, 32'd0);
    check("rst_b_outputs", {grant_b, pending_b, eval_in_b, resp_valid_b, resp_id_b,
                            resp_value_b, coalesced_b, busy_b}, 32'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      req_in_a = 8'($urandom);
      req_in_a[vecs[v].id*2 +: 2] = vecs[v].op;
      req_a = 4'b0001 << vecs[v].id;
      q_a.push_back(mk(2'(vecs[v].id), vecs[v].val));
      tick();
      req_a = 4'b0000;
      check("vec_pending", pending_a, 4'b0001 << vecs[v].id);
      check("vec_grant_idle", grant_a, 4'b0000);
      tick();
      check("vec_grant", grant_a, 4'b0001 << vecs[v].id);
      check("vec_eval_in", eval_in_a, vecs[v].op);
      check("vec_busy", busy_a, 1'b1);
      tick();
      check("vec_resp_valid", resp_valid_a, 1'b1);
      check("vec_pending_clr", pending_a, 4'b0000);
      check("vec_grant_clr", grant_a, 4'b0000);
      tick();
      check("vec_resp_pulse", resp_valid_a, 1'b0);
    end

    // Simultaneous requests 0,1,3 with rr_ptr back at 0 after servicing 3.
    resp_cyc_a.delete();
    req_in_a = 8'b00_10_01_11;
    base = n_resp_a;
    q_a.push_back(mk(2'd0, 1'b0));
    q_a.push_back(mk(2'd1, 1'b1));
    q_a.push_back(mk(2'd3, 1'b1));
    req_a = 4'b1011;
    tick();
    req_a = 4'b0000;
    wait_resp("burst1_count", 1'b0, base + 3, 20);
    check("burst1_cycles", resp_cyc_a.size(), 3);
    if (resp_cyc_a.size() >= 3) begin
      check("burst1_gap01", resp_cyc_a[1] - resp_cyc_a[0], 2);
      check("burst1_gap13", resp_cyc_a[2] - resp_cyc_a[1], 2);
    end
    tick();
    base = n_resp_a;
    q_a.push_back(mk(2'd0, 1'b0));
    q_a.push_back(mk(2'd1, 1'b1));
    req_a = 4'b0011;
    tick();
    req_a = 4'b0000;
    wait_resp("burst2_count", 1'b0, base + 2, 20);
    tick();

    // Re-request of id 0 on its own completion edge yields a second service.
    req_in_a = 8'b0000_0001;
    base = n_resp_a;
    q_a.push_back(mk(2'd0, 1'b1));
    q_a.push_back(mk(2'd0, 1'b1));
    req_a = 4'b0001;
    tick();
    req_a = 4'b0000;
    tick();
    check("sbc_grant", grant_a, 4'b0001);
    req_a = 4'b0001;
    tick();
    req_a = 4'b0000;
    check("sbc_resp_valid", resp_valid_a, 1'b1);
    check("sbc_pending_kept", pending_a, 4'b0001);
    check("sbc_no_coalesce", coalesced_a, 1'b0);
    tick();
    check("sbc_regrant", grant_a, 4'b0001);
    wait_resp("sbc_count", 1'b0, base + 2, 10);
    tick();

    // Coalescing on the latency-3 instance: three request cycles, one response.
    req_in_b = 8'b0000_1000;
    base = n_resp_b;
    c0 = n_coal_b;
    q_b.push_back(mk(2'd1, 1'b1));
    req_b = 4'b0010;
    repeat (3) tick();
    req_b = 4'b0000;
    check("coal_pending", pending_b, 4'b0010);
    wait_resp("coal_resp", 1'b1, base + 1, 20);
    repeat (4) tick();
    check("coal_resp_once", n_resp_b, base + 1);
    check("coal_pulses", n_coal_b - c0, 2);

    // Latency 3: operands sampled at grant, response exactly 5 edges after request.
    req_in_b = 8'b0000_1100;
    base = n_resp_b;
    q_b.push_back(mk(2'd1, 1'b0));
    req_b = 4'b0010;
    tick();
    req_b = 4'b0000;
    tick();
    check("lat_grant", grant_b, 4'b0010);
    check("lat_eval_in", eval_in_b, 2'b11);
    req_in_b = 8'h00;
    tick();
    check("lat_edge3", resp_valid_b, 1'b0);
    tick();
    check("lat_edge4", resp_valid_b, 1'b0);
    check("lat_busy4", busy_b, 1'b1);
    check("lat_eval_hold", eval_in_b, 2'b11);
    tick();
    check("lat_edge5", resp_valid_b, 1'b1);
    check("lat_busy5", busy_b, 1'b0);
    tick();
    check("lat_count", n_resp_b, base + 1);

    // Reset while counter==1: evaluation abandoned, nothing returned afterwards.
    req_in_b = 8'($urandom);
    req_b = 4'b0100;
    tick();
    req_b = 4'b0000;
    repeat (3) tick();
    check("rstmid_busy", busy_b, 1'b1);
    rst = 1'b1;
    #1;
    check("rstmid_outputs", {grant_b, pending_b, eval_in_b, resp_valid_b, resp_id_b,
                             resp_value_b, coalesced_b, busy_b}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    base = n_resp_b;
    repeat (8) tick();
    check("rstmid_no_resp", n_resp_b, base);
    check("rstmid_pending", pending_b, 4'b0000);

    // After reset rr_ptr is 0, so requests 0 and 3 are serviced 0 first.
    req_in_b = 8'b01_00_00_11;
    q_b.push_back(mk(2'd0, 1'b0));
    q_b.push_back(mk(2'd3, 1'b1));
    req_b = 4'b1001;
    tick();
    req_b = 4'b0000;
    wait_resp("recover_count", 1'b1, base + 2, 20);
    repeat (3) tick();

    check("q_a_drained", q_a.size(), 0);
    check("q_b_drained", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
